// File: rtl/usrt_pkg.sv
// Shared types and constants for the synchronous serial transmit controller.
package usrt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int FRAME_BITS = 11;
    localparam int MIN_BAUD   = 2;

endpackage

// File: rtl/usrt_baud_gen.sv
// Bit-period down-counter: flags the last cycle of each bit and produces the
// registered serial-clock phase (low for the first half of a bit).
module usrt_baud_gen #(
    parameter int BAUD_W = 14
) (
    input  logic              i_Pclk,
    input  logic              i_Reset_n,
    input  logic [BAUD_W-1:0] period,
    input  logic              restart,
    input  logic              run,
    input  logic              run_next,
    output logic              bit_end,
    output logic              sclk
);

    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic              sclk_q, sclk_d;

    always_comb begin
        cnt_d = '0;
        if (run_next) begin
            if (restart || cnt_q == '0)
                cnt_d = period - 1'b1;
            else
                cnt_d = cnt_q - 1'b1;
        end
    end

    // High once fewer than ceil(P/2) cycles remain in the bit.
    assign sclk_d  = ~run_next | (cnt_d < (period - (period >> 1)));
    assign bit_end = run & (cnt_q == '0);
    assign sclk    = sclk_q;

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/usrt_tx_ctrl.sv
// Synchronous serial transmitter: start, DATA_W data bits LSB-first, parity, stop.
//   state  | meaning
//   IDLE   | line high, accepting a byte when no config write is in progress
//   START  | start bit (0)
//   DATA   | data bits, LSB first
//   PARITY | parity bit latched at accept
//   STOP   | stop bit (1), then back to IDLE with a done pulse
module usrt_tx_ctrl
    import usrt_pkg::*;
#(
    parameter int BAUD_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              i_Pclk,
    input  logic              i_Reset_n,
    input  logic [BAUD_W-1:0] i_Baud,
    input  logic              i_Parity,
    input  logic              i_Cfg_Ready,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Valid,
    output logic              o_Ready,
    output logic              o_Tx,
    output logic              o_Sclk,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_q, state_d;
    logic              alive_q;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q;
    logic [IDX_W-1:0]  idx_q;
    logic [BAUD_W-1:0] period_q, period_sel, p_eff;
    logic              xfer, bit_end;

    assign p_eff      = (i_Baud < BAUD_W'(MIN_BAUD)) ? BAUD_W'(MIN_BAUD) : i_Baud;
    assign o_Ready    = alive_q & (state_q == ST_IDLE) & ~i_Cfg_Ready;
    assign xfer       = i_Valid & o_Ready;
    assign period_sel = xfer ? p_eff : period_q;
    assign o_Busy     = (state_q != ST_IDLE);
    assign o_Tx       = tx_q;
    assign o_Done     = done_q;

    usrt_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
        .i_Pclk    (i_Pclk),
        .i_Reset_n (i_Reset_n),
        .period    (period_sel),
        .restart   (xfer),
        .run       (o_Busy),
        .run_next  (state_d != ST_IDLE),
        .bit_end   (bit_end),
        .sclk      (o_Sclk)
    );

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            alive_q <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (xfer) state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && idx_q == IDX_W'(DATA_W - 1)) state_d = ST_PARITY;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_q == ST_STOP) & bit_end;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        if (xfer)
            shreg_d = i_Data;
        else if (state_q == ST_DATA && bit_end)
            shreg_d = shreg_q >> 1;
    end

    // Byte, parity and period are frozen at accept for the whole frame.
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            shreg_q  <= '0;
            par_q    <= 1'b0;
            idx_q    <= '0;
            period_q <= BAUD_W'(MIN_BAUD);
        end else if (xfer) begin
            shreg_q  <= shreg_d;
            par_q    <= (^i_Data) ^ i_Parity;
            idx_q    <= '0;
            period_q <= p_eff;
        end else if (state_q == ST_DATA && bit_end) begin
            shreg_q  <= shreg_d;
            idx_q    <= idx_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// Directed bench for usrt_tx_ctrl: frame shape, parity, period clamp,
// config freezing, back-to-back flow and reset abort.
module tb_usrt_tx_ctrl;
    import usrt_pkg::*;

    logic        i_Pclk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic [13:0] i_Baud = 14'd86;
    logic        i_Parity = 1'b0;
    logic        i_Cfg_Ready = 1'b0;
    logic [7:0]  i_Data = 8'h00;
    logic        i_Valid = 1'b0;
    logic        o_Ready, o_Tx, o_Sclk, o_Busy, o_Done;

    int n_chk = 0;
    int n_pass = 0;
    int lat;

    usrt_tx_ctrl #(.BAUD_W(14), .DATA_W(8)) dut (
        .i_Pclk      (i_Pclk),
        .i_Reset_n   (i_Reset_n),
        .i_Baud      (i_Baud),
        .i_Parity    (i_Parity),
        .i_Cfg_Ready (i_Cfg_Ready),
        .i_Data      (i_Data),
        .i_Valid     (i_Valid),
        .o_Ready     (o_Ready),
        .o_Tx        (o_Tx),
        .o_Sclk      (o_Sclk),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
    );

    always #5 i_Pclk = ~i_Pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge with i_Valid already driven; returns on the accept edge.
    task automatic wait_accept(output int l);
        l = 0;
        while (!(o_Ready && i_Valid) && l < 40) begin
            @(negedge i_Pclk);
            l++;
        end
        chk("accept", {31'd0, o_Ready}, 32'd1);
        @(posedge i_Pclk);
    endtask

    task automatic check_frame(input logic [7:0] d, input logic exp_par, input int p,
                               input bit keep, input int chg, input logic [13:0] new_baud);
        int   tx_err, sck_err, c;
        logic exp_tx;
        for (int b = 0; b < FRAME_BITS; b++) begin
            tx_err  = 0;
            sck_err = 0;
            case (b)
                0:       exp_tx = 1'b0;
                9:       exp_tx = exp_par;
                10:      exp_tx = 1'b1;
                default: exp_tx = d[b-1];
            endcase
            for (int k = 0; k < p; k++) begin
                @(negedge i_Pclk);
                c = b * p + k + 1;
                if (o_Tx !== exp_tx || o_Busy !== 1'b1 || o_Done !== 1'b0) tx_err++;
                if (o_Sclk !== ((k >= p / 2) ? 1'b1 : 1'b0)) sck_err++;
                if (c == 1 && !keep) i_Valid = 1'b0;
                if (c == chg) begin
                    i_Baud      = new_baud;
                    i_Cfg_Ready = 1'b1;
                    i_Parity    = ~i_Parity;
                end
                if (c == chg + 1) i_Cfg_Ready = 1'b0;
            end
            chk($sformatf("d%02h_bit%0d_tx", d, b), tx_err, 0);
            chk($sformatf("d%02h_bit%0d_sclk", d, b), sck_err, 0);
        end
        // First IDLE cycle after the frame: 11*P + 1 cycles after the accept edge.
        @(negedge i_Pclk);
        chk("done_pulse", {31'd0, o_Done}, 32'd1);
        chk("idle_busy", {31'd0, o_Busy}, 32'd0);
        chk("idle_tx", {31'd0, o_Tx}, 32'd1);
        chk("idle_sclk", {31'd0, o_Sclk}, 32'd1);
        chk("idle_ready", {31'd0, o_Ready}, 32'd1);
        if (!keep) begin
            @(negedge i_Pclk);
            chk("done_clear", {31'd0, o_Done}, 32'd0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        #23;
        chk("rst_tx", {31'd0, o_Tx}, 32'd1);
        chk("rst_sclk", {31'd0, o_Sclk}, 32'd1);
        chk("rst_busy", {31'd0, o_Busy}, 32'd0);
        chk("rst_done", {31'd0, o_Done}, 32'd0);
        chk("rst_ready", {31'd0, o_Ready}, 32'd0);
        @(negedge i_Pclk);
        i_Reset_n = 1'b1;
        @(posedge i_Pclk);
        #1 chk("ready_after_release", {31'd0, o_Ready}, 32'd1);
        @(negedge i_Pclk);

        // P=86, even parity, 0xA5: parity 0, done in the 947th cycle
        i_Baud = 14'd86; i_Parity = 1'b0; i_Data = 8'hA5; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'hA5, 1'b0, 86, 1'b0, -1, 14'd0);

        i_Baud = 14'd3; i_Parity = 1'b1; i_Data = 8'h00; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'h00, 1'b1, 3, 1'b0, -1, 14'd0);
        i_Parity = 1'b0; i_Data = 8'hFF; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'hFF, 1'b0, 3, 1'b0, -1, 14'd0);

        // period clamp
        i_Baud = 14'd0; i_Data = 8'h5A; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'h5A, 1'b0, 2, 1'b0, -1, 14'd0);
        i_Baud = 14'd1; i_Data = 8'h01; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'h01, 1'b1, 2, 1'b0, -1, 14'd0);

        // config change during DATA bit 3 (frame bit 4) must not disturb the frame
        i_Baud = 14'd86; i_Parity = 1'b1; i_Data = 8'h33; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'h33, 1'b1, 86, 1'b0, 4 * 86 + 10, 14'd173);
        chk("parity_flipped", {31'd0, i_Parity}, 32'd0);
        i_Data = 8'hC1; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'hC1, 1'b1, 173, 1'b0, -1, 14'd0);

        // valid together with a config write is deferred one cycle
        i_Baud = 14'd5; i_Data = 8'h81; i_Parity = 1'b0; i_Valid = 1'b1; i_Cfg_Ready = 1'b1;
        #1 chk("ready_during_cfg", {31'd0, o_Ready}, 32'd0);
        @(negedge i_Pclk);
        i_Cfg_Ready = 1'b0;
        chk("not_accepted_with_cfg", {31'd0, o_Busy}, 32'd0);
        #1 chk("ready_after_cfg", {31'd0, o_Ready}, 32'd1);
        wait_accept(lat);
        chk("defer_latency", lat, 0);
        check_frame(8'h81, 1'b0, 5, 1'b0, -1, 14'd0);

        // three back-to-back frames with i_Valid held high
        i_Data = 8'h12; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'h12, 1'b0, 5, 1'b1, -1, 14'd0);
        i_Data = 8'h34;
        wait_accept(lat);
        chk("gap_1", lat, 0);
        check_frame(8'h34, 1'b1, 5, 1'b1, -1, 14'd0);
        i_Data = 8'h7E;
        wait_accept(lat);
        chk("gap_2", lat, 0);
        check_frame(8'h7E, 1'b0, 5, 1'b0, -1, 14'd0);

        // reset during PARITY aborts the frame
        i_Baud = 14'd4; i_Data = 8'h3C; i_Parity = 1'b0; i_Valid = 1'b1;
        wait_accept(lat);
        for (int c = 1; c <= 37; c++) begin
            @(negedge i_Pclk);
            if (c == 1) i_Valid = 1'b0;
        end
        chk("pre_abort_tx", {31'd0, o_Tx}, 32'd0);
        chk("pre_abort_sclk", {31'd0, o_Sclk}, 32'd0);
        chk("pre_abort_busy", {31'd0, o_Busy}, 32'd1);
        #2 i_Reset_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, o_Tx}, 32'd1);
        chk("abort_sclk", {31'd0, o_Sclk}, 32'd1);
        chk("abort_busy", {31'd0, o_Busy}, 32'd0);
        chk("abort_ready", {31'd0, o_Ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_Pclk);
            chk("abort_no_done", {31'd0, o_Done}, 32'd0);
        end
        i_Reset_n = 1'b1;
        @(posedge i_Pclk);
        #1 chk("ready_after_abort", {31'd0, o_Ready}, 32'd1);
        chk("no_done_after_abort", {31'd0, o_Done}, 32'd0);
        @(negedge i_Pclk);
        i_Data = 8'h96; i_Parity = 1'b1; i_Valid = 1'b1;
        wait_accept(lat);
        check_frame(8'h96, 1'b1, 4, 1'b0, -1, 14'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
